// File: rtl/iterative_alu_if.sv
// Operand/result handshake bundle for iterative_alu: request side (iValid/oReady)
// and result side (oValid/iReady) with their payloads.
interface iterative_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             iValid;
  logic             oReady;
  logic [3:0]       iAluCtrl;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oResult;
  logic             oZero;
  logic             oBranchTaken;

  modport master (
    output iValid, iAluCtrl, iA, iB, iReady,
    input  oReady, oValid, oResult, oZero, oBranchTaken
  );

  modport slave (
    input  iValid, iAluCtrl, iA, iB, iReady,
    output oReady, oValid, oResult, oZero, oBranchTaken
  );
endinterface

// File: rtl/iterative_alu.sv
// Execute-stage ALU: single-cycle arithmetic/logic/branch ops, iterative shifts
// of up to SHIFT_STEP bits per cycle, valid/ready on both request and result.
module iterative_alu #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input logic           iClk,
  input logic           iRst,
  iterative_alu_if.slave bus
);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;
  localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shKind_t;

  state_t           state;
  shKind_t          kind;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    remaining;
  logic             zero;
  logic             branch;

  logic [WIDTH-1:0] aluRes;
  logic             aluBr;
  logic             isShift;
  shKind_t          aluKind;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] diff;
  logic             sLess;

  logic [CW-1:0]    step;
  logic [CW-1:0]    remNext;
  logic [WIDTH-1:0] shifted;

  assign bus.oReady       = (state == IDLE) && !iRst;
  assign bus.oValid       = (state == DONE);
  assign bus.oResult      = result;
  assign bus.oZero        = zero;
  assign bus.oBranchTaken = branch;

  always_comb begin
    shamt   = bus.iB[SW-1:0];
    diff    = bus.iA - bus.iB;
    sLess   = $signed(bus.iA) < $signed(bus.iB);
    aluRes  = bus.iA + bus.iB;
    aluBr   = 1'b0;
    isShift = 1'b0;
    aluKind = SH_LL;
    case (bus.iAluCtrl)
      4'b1000: begin aluRes = diff; aluBr = (bus.iA == bus.iB); end
      4'b1100: begin aluRes = diff; aluBr = (bus.iA != bus.iB); end
      4'b1010: begin aluRes = diff; aluBr = sLess; end
      4'b1110: begin aluRes = diff; aluBr = !sLess; end
      4'b0001: begin aluRes = bus.iA; isShift = 1'b1; aluKind = SH_LL; end
      4'b1001: begin aluRes = bus.iA; isShift = 1'b1; aluKind = SH_RL; end
      4'b1101: begin aluRes = bus.iA; isShift = 1'b1; aluKind = SH_RA; end
      4'b0010: aluRes = {{(WIDTH-1){1'b0}}, sLess};
      4'b0011: aluRes = {{(WIDTH-1){1'b0}}, (bus.iA < bus.iB)};
      4'b0100: aluRes = bus.iA ^ bus.iB;
      4'b0110: aluRes = bus.iA | bus.iB;
      4'b0111: aluRes = bus.iA & bus.iB;
      default: aluRes = bus.iA + bus.iB;
    endcase
  end

  // SRA keeps the captured sign because the working value's MSB never changes.
  always_comb begin
    step    = (remaining < STEP) ? remaining : STEP;
    remNext = remaining - step;
    case (kind)
      SH_RL:   shifted = result >> step;
      SH_RA:   shifted = $signed(result) >>> step;
      default: shifted = result << step;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      kind      <= SH_LL;
      result    <= '0;
      remaining <= '0;
      zero      <= 1'b0;
      branch    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iValid) begin
            kind <= aluKind;
            if (isShift && (shamt != '0)) begin
              state     <= SHIFT;
              result    <= bus.iA;
              remaining <= {1'b0, shamt};
              zero      <= 1'b0;
              branch    <= 1'b0;
            end else begin
              state  <= DONE;
              result <= aluRes;
              zero   <= (aluRes == '0);
              branch <= aluBr;
            end
          end
        end
        SHIFT: begin
          result    <= shifted;
          remaining <= remNext;
          if (remNext == '0) begin
            state <= DONE;
            zero  <= (shifted == '0);
          end
        end
        DONE: begin
          if (bus.iReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu: vector table for every op class plus
// backpressure and mid-shift reset sequences.
module tb_iterative_alu;
  logic clk;
  logic rst;
  int   passCnt;
  int   totalCnt;

  iterative_alu_if #(.WIDTH(32)) bus ();

  iterative_alu #(.WIDTH(32), .SHIFT_STEP(1)) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    logic        expZero;
    logic        expBr;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int n;
    bus.iAluCtrl = c;
    bus.iA       = a;
    bus.iB       = b;
    bus.iValid   = 1'b1;
    n = 0;
    while (!bus.oReady && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.oReady) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.iValid   = 1'b0;
    bus.iA       = $urandom;
    bus.iB       = $urandom;
    bus.iAluCtrl = 4'($urandom);
  endtask

  task automatic waitValid(output int lat);
    lat = 1;
    while (!bus.oValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    passCnt  = 0;
    totalCnt = 0;
    vecs = '{
      '{"add_wrap",  4'b0000, 32'h7,        32'hFFFFFFFF, 32'h6,        1'b0, 1'b0, 1},
      '{"beq_eq",    4'b1000, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b1, 1},
      '{"bge_m1_1",  4'b1110, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b0, 1'b0, 1},
      '{"bge_eq",    4'b1110, 32'h3,        32'h3,        32'h0,        1'b1, 1'b1, 1},
      '{"sra31",     4'b1101, 32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0, 32},
      '{"srl31",     4'b1001, 32'h80000000, 32'd31,       32'h1,        1'b0, 1'b0, 32},
      '{"sra_pos4",  4'b1101, 32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 1'b0, 1'b0, 5},
      '{"sll4",      4'b0001, 32'h3,        32'd4,        32'h30,       1'b0, 1'b0, 5},
      '{"sll_sh0",   4'b0001, 32'h5,        32'h20,       32'h5,        1'b0, 1'b0, 1},
      '{"slt",       4'b0010, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1},
      '{"sltu",      4'b0011, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1},
      '{"code0101",  4'b0101, 32'h2,        32'h3,        32'h5,        1'b0, 1'b0, 1},
      '{"code1111",  4'b1111, 32'h1,        32'h2,        32'h3,        1'b0, 1'b0, 1},
      '{"code1011",  4'b1011, 32'h1,        32'h1,        32'h2,        1'b0, 1'b0, 1},
      '{"sub_ne",    4'b1000, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0, 1'b0, 1},
      '{"bne",       4'b1100, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0, 1'b1, 1},
      '{"blt",       4'b1010, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b0, 1'b1, 1},
      '{"xor",       4'b0100, 32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0, 1'b0, 1},
      '{"or",        4'b0110, 32'hF0F0,     32'h0F0F,     32'hFFFF,     1'b0, 1'b0, 1},
      '{"and",       4'b0111, 32'hF0F0,     32'h0FF0,     32'h00F0,     1'b0, 1'b0, 1}
    };

    rst          = 1'b1;
    bus.iValid   = 1'b0;
    bus.iAluCtrl = 4'h0;
    bus.iA       = '0;
    bus.iB       = '0;
    bus.iReady   = 1'b1;
    #1;
    chk("rst_oValid", 32'(bus.oValid), 32'd0);
    chk("rst_oResult", bus.oResult, 32'd0);
    chk("rst_oReady_in_reset", 32'(bus.oReady), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_oReady_after", 32'(bus.oReady), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      waitValid(lat);
      chk({vecs[i].name, "_result"}, bus.oResult, vecs[i].expRes);
      chk({vecs[i].name, "_zero"}, 32'(bus.oZero), 32'(vecs[i].expZero));
      chk({vecs[i].name, "_branch"}, 32'(bus.oBranchTaken), 32'(vecs[i].expBr));
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].expLat));
      @(posedge clk); #1;
    end

    // Backpressure: result held, requests ignored while DONE.
    bus.iReady = 1'b0;
    issue(4'b0000, 32'h10, 32'h20);
    waitValid(lat);
    held = bus.oResult;
    chk("bp_result", held, 32'h30);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.iValid = 1'b1; bus.iAluCtrl = 4'b0100; bus.iA = 32'hAAAA; bus.iB = 32'h5555;
      end
      if (i == 5) bus.iValid = 1'b0;
      @(posedge clk); #1;
      chk("bp_oValid", 32'(bus.oValid), 32'd1);
      chk("bp_stable", bus.oResult, 32'h30);
      chk("bp_oReady", 32'(bus.oReady), 32'd0);
    end
    bus.iReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_oValid", 32'(bus.oValid), 32'd0);
    chk("bp_release_oReady", 32'(bus.oReady), 32'd1);
    @(posedge clk); #1;
    chk("bp_no_stray_accept", 32'(bus.oValid), 32'd0);

    // Reset in the middle of a long shift.
    issue(4'b0001, 32'h1, 32'd20);
    repeat (5) begin @(posedge clk); #1; end
    chk("midshift_busy", 32'(bus.oValid), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_oValid", 32'(bus.oValid), 32'd0);
    chk("midrst_oResult", bus.oResult, 32'd0);
    chk("midrst_oReady", 32'(bus.oReady), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("postrst_oReady", 32'(bus.oReady), 32'd1);
    issue(4'b0000, 32'h1, 32'h1);
    waitValid(lat);
    chk("postrst_add", bus.oResult, 32'h2);
    chk("postrst_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
